// File: rtl/init_sequencer.sv
// Power-up / re-initialisation sequencer: steps RST_HOLD -> CONFIG -> CALIB -> RUN
// with per-phase timeout, bounded retry and a fault latch; drives the init mux phase select.
module init_sequencer #(
   parameter int RESET_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRY      = 3,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic       cfg_done,
   input  logic       cal_done,
   output logic [1:0] init_sel,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt
);

   typedef enum logic [2:0] {
      RST_HOLD,
      CONFIG,
      CALIB,
      RUN,
      FAULT
   } state_t;

   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [3:0]       retry_nx;
   logic [3:0]       retry_inc;
   logic [1:0]       sel_nx;
   logic             ready_nx;
   logic             fault_nx;

   assign retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CNT_W'(1);
      retry_nx = retry_cnt;
      case (state)
         RST_HOLD: begin
            if (cnt == RESET_LAST) state_nx = CONFIG;
         end
         CONFIG: begin
            if (cfg_done) begin
               state_nx = CALIB;
            end else if (cnt == TIMEOUT_LAST) begin
               retry_nx = retry_inc;
               state_nx = (retry_cnt == RETRY_LIMIT) ? FAULT : RST_HOLD;
            end
         end
         CALIB: begin
            if (cal_done) begin
               state_nx = RUN;
            end else if (cnt == TIMEOUT_LAST) begin
               retry_nx = retry_inc;
               state_nx = (retry_cnt == RETRY_LIMIT) ? FAULT : RST_HOLD;
            end
         end
         RUN, FAULT: begin
            cnt_nx = cnt;
         end
         default: begin
            state_nx = RST_HOLD;
         end
      endcase

      if (restart) begin
         state_nx = RST_HOLD;
         retry_nx = '0;
      end

      // restart while already in RST_HOLD is not a state change but must still clear the count
      if ((state_nx != state) || restart) cnt_nx = '0;
   end

   always_comb begin
      sel_nx   = 2'b00;
      ready_nx = 1'b0;
      fault_nx = 1'b0;
      case (state_nx)
         CONFIG:  sel_nx = 2'b01;
         CALIB:   sel_nx = 2'b10;
         RUN: begin
            sel_nx   = 2'b11;
            ready_nx = 1'b1;
         end
         FAULT:   fault_nx = 1'b1;
         default: sel_nx = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_HOLD;
         cnt       <= '0;
         retry_cnt <= '0;
         init_sel  <= 2'b00;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         retry_cnt <= retry_nx;
         init_sel  <= sel_nx;
         ready     <= ready_nx;
         fault     <= fault_nx;
      end
   end

endmodule

// File: tb/tb_init_sequencer.sv
// Self-checking bench for init_sequencer: scenarios are described as phase durations and
// expanded into a per-cycle timeline of stimulus and expected outputs.
module tb_init_sequencer;

   localparam int RESET_CYCLES   = 16;
   localparam int TIMEOUT_CYCLES = 1024;
   localparam int MAX_RETRY      = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       restart = 1'b0;
   logic       cfg_done = 1'b0;
   logic       cal_done = 1'b0;
   logic [1:0] init_sel;
   logic       ready;
   logic       fault;
   logic [3:0] retry_cnt;

   always #5 clk = ~clk;

   init_sequencer #(
      .RESET_CYCLES  (RESET_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_RETRY     (MAX_RETRY),
      .CNT_W         (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .restart  (restart),
      .cfg_done (cfg_done),
      .cal_done (cal_done),
      .init_sel (init_sel),
      .ready    (ready),
      .fault    (fault),
      .retry_cnt(retry_cnt)
   );

   typedef struct {
      logic       rst;
      logic       restart;
      logic       cfg;
      logic       cal;
      logic [7:0] exp;   // {init_sel, ready, fault, retry_cnt} after the edge
   } step_t;

   step_t      q[$];
   int         pend_cfg = -1;
   int         pend_cal = -1;
   int         b_rc = 0;
   int         passed = 0;
   int         total = 0;
   logic [7:0] obs;

   function automatic logic pick(input int mode);
      if (mode < 0) return logic'($urandom_range(0, 1));
      return (mode != 0);
   endfunction

   task automatic push(input logic [1:0] sel, input logic rdy, input logic flt,
                       input int cm, input int am, input logic r, input logic rs);
      step_t s;
      s.rst     = r;
      s.restart = rs;
      s.cfg     = pick(cm);
      s.cal     = pick(am);
      s.exp     = {sel, rdy, flt, 4'(b_rc)};
      q.push_back(s);
   endtask

   // First cycle of a phase: carries any done/no-done level the previous phase demanded.
   task automatic push_entry(input logic [1:0] sel, input logic rdy, input logic flt,
                             input logic r, input logic rs);
      push(sel, rdy, flt, pend_cfg, pend_cal, r, rs);
      pend_cfg = -1;
      pend_cal = -1;
   endtask

   task automatic b_hold(input logic r, input logic rs, input int reps);
      if (r || rs) b_rc = 0;
      push_entry(2'b00, 1'b0, 1'b0, r, rs);
      for (int i = 1; i < reps; i++) push(2'b00, 1'b0, 1'b0, -1, -1, r, rs);
      for (int i = 1; i < RESET_CYCLES; i++) push(2'b00, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
   endtask

   // lat >= 0: done arrives after lat+1 cycles in phase; lat < 0: timeout; cut > 0: interrupted.
   // status: 0 done, 1 timeout with retry, 2 timeout into fault, 3 cut
   task automatic b_phase(input logic [1:0] sel, input bit is_cal, input int lat,
                          input int cut, output int status);
      int n;
      push_entry(sel, 1'b0, 1'b0, 1'b0, 1'b0);
      n = (cut > 0) ? cut - 1 : ((lat >= 0) ? lat : TIMEOUT_CYCLES - 1);
      for (int i = 0; i < n; i++)
         push(sel, 1'b0, 1'b0, is_cal ? -1 : 0, is_cal ? 0 : -1, 1'b0, 1'b0);
      if (cut > 0) begin
         status = 3;
      end else if (lat >= 0) begin
         if (is_cal) pend_cal = 1; else pend_cfg = 1;
         status = 0;
      end else begin
         if (is_cal) pend_cal = 0; else pend_cfg = 0;
         status = (b_rc == MAX_RETRY) ? 2 : 1;
         if (b_rc < 15) b_rc++;
      end
   endtask

   task automatic b_terminal(input logic [1:0] sel, input logic rdy, input logic flt, input int n);
      push_entry(sel, rdy, flt, 1'b0, 1'b0);
      for (int i = 1; i < n; i++) push(sel, rdy, flt, -1, -1, 1'b0, 1'b0);
   endtask

   task automatic plan(output int lat, output int cut);
      int r;
      r   = $urandom_range(0, 15);
      cut = 0;
      if (r == 0)      lat = -1;
      else if (r == 1) lat = TIMEOUT_CYCLES - 1;
      else if (r == 2) begin lat = 0; cut = $urandom_range(1, 40); end
      else             lat = $urandom_range(0, 20);
   endtask

   task automatic b_random_run();
      int st, lat, cut;
      st = 1;
      for (int k = 0; k < 8 && st == 1; k++) begin
         plan(lat, cut);
         b_phase(2'b01, 1'b0, lat, cut, st);
         if (st == 0) begin
            plan(lat, cut);
            b_phase(2'b10, 1'b1, lat, cut, st);
            if (st == 0) b_terminal(2'b11, 1'b1, 1'b0, $urandom_range(1, 30));
         end
         if (st == 1)      b_hold(1'b0, 1'b0, 1);
         else if (st == 2) b_terminal(2'b00, 1'b0, 1'b1, $urandom_range(1, 30));
      end
   endtask

   task automatic drive_step(input step_t s);
      @(negedge clk);
      rst      = s.rst;
      restart  = s.restart;
      cfg_done = s.cfg;
      cal_done = s.cal;
      @(posedge clk);
      #1;
      obs = {init_sel, ready, fault, retry_cnt};
   endtask

   task automatic test_reset();
      q.delete();
      b_hold(1'b1, 1'b0, 3);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL reset step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_min_latency();
      int st;
      q.delete();
      b_hold(1'b1, 1'b0, 1);
      b_phase(2'b01, 1'b0, 0, 0, st);
      b_phase(2'b10, 1'b1, 0, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 4);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL min_latency step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_nominal();
      int st;
      q.delete();
      b_hold(1'b1, 1'b0, 1);
      b_phase(2'b01, 1'b0, 5, 0, st);
      b_phase(2'b10, 1'b1, 7, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 10);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL nominal step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_config_timeout();
      int st;
      q.delete();
      b_hold(1'b0, 1'b1, 1);
      b_phase(2'b01, 1'b0, -1, 0, st);
      b_hold(1'b0, 1'b0, 1);
      b_phase(2'b01, 1'b0, 3, 0, st);
      b_phase(2'b10, 1'b1, 2, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 5);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL config_timeout step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_fault();
      int st;
      q.delete();
      b_hold(1'b0, 1'b1, 1);
      st = 1;
      for (int k = 0; k < 8 && st == 1; k++) begin
         b_phase(2'b01, 1'b0, -1, 0, st);
         if (st == 1) b_hold(1'b0, 1'b0, 1);
      end
      b_terminal(2'b00, 1'b0, 1'b1, 2000);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL fault step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_restart();
      int st;
      q.delete();
      b_hold(1'b0, 1'b1, 1);
      b_phase(2'b01, 1'b0, 2, 0, st);
      b_phase(2'b10, 1'b1, 3, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 20);
      b_hold(1'b0, 1'b1, 1);
      b_phase(2'b01, 1'b0, 0, 0, st);
      b_phase(2'b10, 1'b1, 4, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 5);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL restart step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_restart_held();
      int st;
      q.delete();
      b_hold(1'b0, 1'b1, $urandom_range(2, 6));
      b_phase(2'b01, 1'b0, $urandom_range(0, 9), 0, st);
      b_phase(2'b10, 1'b1, $urandom_range(0, 9), 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 3);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL restart_held step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_boundary();
      int st;
      q.delete();
      b_hold(1'b0, 1'b1, 1);
      b_phase(2'b01, 1'b0, -1, 0, st);
      b_hold(1'b0, 1'b0, 1);
      b_phase(2'b01, 1'b0, TIMEOUT_CYCLES - 1, 0, st);
      b_phase(2'b10, 1'b1, TIMEOUT_CYCLES - 1, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 5);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL boundary step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_calib();
      int st;
      q.delete();
      b_hold(1'b0, 1'b1, 1);
      b_phase(2'b10 ^ 2'b11, 1'b0, -1, 0, st);
      b_hold(1'b0, 1'b0, 1);
      b_phase(2'b01, 1'b0, 4, 0, st);
      b_phase(2'b10, 1'b1, 0, 501, st);
      b_hold(1'b1, 1'b0, 1);
      b_phase(2'b01, 1'b0, 1, 0, st);
      b_phase(2'b10, 1'b1, 1, 0, st);
      b_terminal(2'b11, 1'b1, 1'b0, 5);
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL reset_mid_calib step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   task automatic test_random();
      q.delete();
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 1) b_hold(1'b1, 1'b0, $urandom_range(1, 3));
         else                           b_hold(1'b0, 1'b1, $urandom_range(1, 3));
         b_random_run();
      end
      foreach (q[i]) begin
         drive_step(q[i]);
         total++;
         if (obs !== q[i].exp)
            $display("FAIL random step %0d: got sel=%b rdy=%b flt=%b rc=%0d, want sel=%b rdy=%b flt=%b rc=%0d",
                     i, obs[7:6], obs[5], obs[4], obs[3:0], q[i].exp[7:6], q[i].exp[5], q[i].exp[4], q[i].exp[3:0]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_min_latency();
      test_nominal();
      test_config_timeout();
      test_fault();
      test_restart();
      test_restart_held();
      test_boundary();
      test_reset_mid_calib();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
- Timed power-up / re-initialisation sequencer for the scope front end.
- Generates the 2-bit phase select that drives the downstream init/reset decode mux. That mux turns the phase into the 6-bit per-subsystem reset/enable vector.
- Steps RESET -> CONFIG -> CALIB -> RUN using handshakes from the configured subsystems.
- Includes timeout, bounded retry and a fault latch. A user restart re-runs the sequence.

Parameters:
- RESET_CYCLES, 16, cycles init_sel is held at 2'b00 per RESET phase; must be >= 1.
- TIMEOUT_CYCLES, 1024, max cycles spent in CONFIG or CALIB waiting for done; must be >= 2.
- MAX_RETRY, 3, timeouts tolerated before entering FAULT; range 0..15.
- CNT_W, 16, phase counter width; must satisfy 2^CNT_W >= max(RESET_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- restart, input, 1, user request to re-run the sequence; sampled level, one cycle is sufficient.
- cfg_done, input, 1, configuration complete from the ADC/config block; level or pulse.
- cal_done, input, 1, calibration complete from the calibration block; level or pulse.
- init_sel, output, 2, phase select to the init/reset mux: 00 RESET, 01 CONFIG, 10 CALIB, 11 RUN.
- ready, output, 1, high only while in RUN.
- fault, output, 1, high only while in FAULT.
- retry_cnt, output, 4, timeouts since the last rst/restart; saturates at 15.

Behaviour:
- All outputs are registered. State and outputs change only on the rising edge of clk.
- Reset (rst high at an edge):
  - state = RST_HOLD, counter = 0, retry_cnt = 0.
  - init_sel = 00, ready = 0, fault = 0.
  - rst has priority over every other input.
- States and init_sel encoding:
  - RST_HOLD: init_sel 00.
  - CONFIG: init_sel 01.
  - CALIB: init_sel 10.
  - RUN: init_sel 11, ready = 1.
  - FAULT: init_sel 00, fault = 1.
- Counter: cleared on every state entry. Increments by 1 each cycle in RST_HOLD, CONFIG and CALIB. Held in RUN and FAULT.
- RST_HOLD: when counter == RESET_CYCLES-1, next state is CONFIG. init_sel is therefore 00 for exactly RESET_CYCLES cycles.
- CONFIG, evaluated in this order:
  - cfg_done = 1: next state CALIB.
  - Else if counter == TIMEOUT_CYCLES-1 (timeout): retry_cnt increments (saturating). If the pre-increment retry_cnt == MAX_RETRY, next state FAULT; otherwise next state RST_HOLD.
  - Else: stay.
- CALIB: same rules as CONFIG using cal_done; a successful done goes to RUN.
- Done and timeout in the same cycle: done wins, no timeout is counted.
- cfg_done in CALIB/RUN and cal_done in CONFIG/RUN are ignored. cal_done in RST_HOLD is ignored.
- RUN: terminal until restart or rst.
- FAULT: terminal until restart or rst.
- restart = 1 in any state (rst low) has priority over all other transitions:
  - next state RST_HOLD, counter = 0, retry_cnt = 0, ready and fault drop in the same update.
  - restart held high keeps the block in RST_HOLD with counter = 0.
- MAX_RETRY = 0: the first timeout goes directly to FAULT.
- Latency: the earliest RUN is RESET_CYCLES + 2 cycles after rst deasserts, when cfg_done and cal_done are both high throughout.
- init_sel is never X after reset. No illegal state is reachable; the default branch returns to RST_HOLD.

Test Plan:
- Nominal (defaults): release rst; cfg_done high 5 cycles after CONFIG entry; cal_done high 7 cycles after CALIB entry -> init_sel shows 00 for 16 cycles, 01 for 6 cycles, 10 for 8 cycles, then 11 with ready = 1, retry_cnt = 0.
- Config timeout with retry: cfg_done held low for the first 1024 CONFIG cycles, then asserted on the second pass -> init_sel returns to 00 for 16 cycles, retry_cnt = 1, the second pass reaches RUN.
- Fault: cfg_done held low forever, MAX_RETRY = 3 -> after the 4th timeout, fault = 1, init_sel = 00, retry_cnt = 4, and the block stays there for ≥ 2000 cycles.
- Restart from FAULT and from RUN: 1-cycle restart pulse -> next cycle init_sel = 00, fault = 0, ready = 0, retry_cnt = 0, counter restarts with a full 16-cycle hold.
- Boundary collision: cal_done asserted exactly on the CALIB cycle with counter == 1023 -> transition to RUN, retry_cnt unchanged.
- Sync reset mid-CALIB (counter = 500): rst high 1 cycle -> all outputs at reset values on the next edge, then a full sequence replays from RST_HOLD.
